// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, access-size codes, alignment rule.
package data_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR      = 2'd2,
      ST_DONE    = 2'd3
   } dmc_state_t;

   localparam logic [2:0] SZ_BYTE  = 3'b001;
   localparam logic [2:0] SZ_HALF  = 3'b011;
   localparam logic [2:0] SZ_WORD  = 3'b111;
   localparam int         SIGN_BIT = 3;

   // Illegal size codes count as misaligned so they never reach the BRAM.
   function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: is_aligned = 1'b1;
         SZ_HALF: is_aligned = ~off[0];
         SZ_WORD: is_aligned = (off == 2'b00);
         default: is_aligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmc_lane_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge into an old word.
module dmc_lane_align
   import data_mem_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [3:0]  sign_mask,
   input  logic [31:0] data,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        sign;

   always_comb begin
      lane_b    = word[{off, 3'b000} +: 8];
      lane_h    = off[1] ? word[31:16] : word[15:0];
      sign      = sign_mask[SIGN_BIT];
      load_data = word;
      case (sign_mask[2:0])
         SZ_BYTE: load_data = {{24{sign & lane_b[7]}}, lane_b};
         SZ_HALF: load_data = {{16{sign & lane_h[15]}}, lane_h};
         default: load_data = word;
      endcase
   end

   always_comb begin
      merged = word;
      case (sign_mask[2:0])
         SZ_BYTE: merged[{off, 3'b000} +: 8] = data[7:0];
         SZ_HALF: begin
            if (off[1]) merged[31:16] = data[15:0];
            else        merged[15:0]  = data[15:0];
         end
         default: merged = data;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle CPU data-port controller for a 1-cycle-latency word BRAM; sub-word stores by read-modify-write.
//  state   | meaning
//  IDLE    | accept request; issue BRAM read for loads and sub-word stores
//  RD_WAIT | BRAM read data arriving, captured into word_q
//  WR      | full-word BRAM write (plain data or merged word)
//  DONE    | result presented, pipeline released for one cycle
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wrdata,
   input  logic              cpu_memwrite,
   input  logic              cpu_memread,
   input  logic [3:0]        cpu_sign_mask,
   output logic [31:0]       cpu_rddata,
   output logic              cpu_stall,
   output logic              cpu_misaligned,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   dmc_state_t         state;
   logic [ADDR_W+1:0]  addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         sm_q;
   logic               store_q;
   logic [31:0]        word_q;

   logic               req;
   logic               aligned;
   logic               start;
   logic               word_store;
   logic [31:0]        load_data;
   logic [31:0]        merged;

   // Request decode is gated by rst_n so every output reads 0 while reset is held.
   assign req        = rst_n & (cpu_memread | cpu_memwrite);
   assign aligned    = is_aligned(cpu_sign_mask[2:0], cpu_addr[1:0]);
   assign start      = (state == ST_IDLE) & req & aligned;
   assign word_store = cpu_memwrite & (cpu_sign_mask[2:0] == SZ_WORD);

   dmc_lane_align u_lane (
      .word      (word_q),
      .off       (addr_q[1:0]),
      .sign_mask (sm_q),
      .data      (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         sm_q    <= '0;
         store_q <= 1'b0;
         word_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= cpu_addr[ADDR_W+1:0];
                  wdata_q <= cpu_wrdata;
                  sm_q    <= cpu_sign_mask;
                  store_q <= cpu_memwrite;
                  state   <= word_store ? ST_WR : ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               word_q <= mem_rdata;
               state  <= store_q ? ST_WR : ST_DONE;
            end
            ST_WR:   state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cpu_stall      = start | (state == ST_RD_WAIT) | (state == ST_WR);
      cpu_misaligned = (state == ST_IDLE) & req & ~aligned;
      mem_en         = (start & ~word_store) | (state == ST_WR);
      mem_we         = (state == ST_WR);
      mem_addr       = '0;
      if (state == ST_WR) mem_addr = addr_q[ADDR_W+1:2];
      else if (start)     mem_addr = cpu_addr[ADDR_W+1:2];
      mem_wdata      = (state == ST_WR) ? merged : 32'h0;
      cpu_rddata     = ((state == ST_DONE) && !store_q) ? load_data : 32'h0;
   end

endmodule
